// File: rtl/i2c_txn_scheduler_pkg.sv
// Shared types and constants for the i2c transaction scheduler: FSM state
// encoding, rsp_err bit positions, default timing constants and a width helper.
package i2c_txn_scheduler_pkg;

    typedef enum logic [2:0] {
        SCHED_IDLE  = 3'd0,
        SCHED_ISSUE = 3'd1,
        SCHED_WAIT  = 3'd2,
        SCHED_RESP  = 3'd3,
        SCHED_GUARD = 3'd4
    } sched_state_e;

    localparam int ERR_NACK_BIT       = 0;
    localparam int ERR_TMO_BIT        = 1;

    localparam int DEF_TIMEOUT_CYCLES = 65535;
    localparam int DEF_GUARD_CYCLES   = 256;
    localparam int DEF_MAX_RETRIES    = 2;

    // Bits needed to hold values 0..num_vals-1 (never less than one bit).
    function automatic int cnt_width(input int num_vals);
        return (num_vals > 1) ? $clog2(num_vals) : 1;
    endfunction

endpackage

// File: rtl/i2c_txn_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 (mod NUM_REQ) and
// returns the first pending request as a one-hot grant plus its index.
module rr_arbiter
    import i2c_txn_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = cnt_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offset);
        return IDX_W'((int'(base) + offset) % NUM_REQ);
    endfunction

    logic hit_s;

    // Scan farthest-first so the closest candidate after ptr is written last and wins.
    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        hit_s = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            hit_s = req[wrap_idx(ptr, i)];
            index = hit_s ? wrap_idx(ptr, i) : index;
            any   = any | hit_s;
        end
        grant[index] = any;
    end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// Round-robin scheduler sharing one i2c_master between NUM_REQ requesters,
// with per-transaction timeout and bus guard gap. Optional NACK retry: I2C_RETRY_EN.
module i2c_txn_scheduler
    import i2c_txn_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_data,
    output logic [1:0]           rsp_err,
    output logic                 busy,
    output logic                 m_start,
    output logic [6:0]           m_addr,
    output logic                 m_rw,
    output logic [7:0]           m_wdata,
    input  logic [7:0]           m_rdata,
    input  logic                 m_done,
    input  logic                 m_ack_error
);

    localparam int IDX_W = cnt_width(NUM_REQ);
    localparam int CNT_W = cnt_width((TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES);
    localparam int RTY_W = cnt_width(MAX_RETRIES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD_CYCLES - 1);

`ifdef I2C_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    sched_state_e       state_r, state_n;
    logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_n;
    logic [NUM_REQ-1:0] gnt_oh_r, gnt_oh_n;
    logic [CNT_W-1:0]   cnt_r, cnt_n;
    logic [RTY_W-1:0]   retry_cnt_r, retry_cnt_n;
    logic               retry_pend_r, retry_pend_n;
    logic               m_done_q_r;

    logic [NUM_REQ-1:0] arb_gnt_s;
    logic [IDX_W-1:0]   arb_idx_s;
    logic               arb_any_s;
    logic               done_edge_s;
    logic               retry_ok_s;

    logic [NUM_REQ-1:0] req_ack_n, rsp_valid_n;
    logic [7:0]         rsp_data_n, m_wdata_n;
    logic [1:0]         rsp_err_n;
    logic [6:0]         m_addr_n;
    logic               m_rw_n;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_r),
        .grant (arb_gnt_s),
        .index (arb_idx_s),
        .any   (arb_any_s)
    );

    assign done_edge_s = m_done & ~m_done_q_r;
    assign retry_ok_s  = RETRY_EN && (retry_cnt_r < RTY_W'(MAX_RETRIES));

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n      = state_r;
        rr_ptr_n     = rr_ptr_r;
        gnt_oh_n     = gnt_oh_r;
        retry_cnt_n  = retry_cnt_r;
        retry_pend_n = retry_pend_r;
        m_addr_n     = m_addr;
        m_rw_n       = m_rw;
        m_wdata_n    = m_wdata;
        req_ack_n    = '0;
        rsp_valid_n  = '0;
        rsp_data_n   = 8'h00;
        rsp_err_n    = 2'b00;
        case (state_r)
            SCHED_IDLE: begin
                if (arb_any_s) begin
                    state_n      = SCHED_ISSUE;
                    rr_ptr_n     = arb_idx_s;
                    gnt_oh_n     = arb_gnt_s;
                    req_ack_n    = arb_gnt_s;
                    m_addr_n     = req_addr[7*arb_idx_s +: 7];
                    m_rw_n       = req_rw[arb_idx_s];
                    m_wdata_n    = req_wdata[8*arb_idx_s +: 8];
                    retry_cnt_n  = '0;
                    retry_pend_n = 1'b0;
                end else begin
                    state_n = SCHED_IDLE;
                end
            end
            SCHED_ISSUE: begin
                state_n = SCHED_WAIT;
            end
            SCHED_WAIT: begin
                // A done edge takes precedence over a timeout expiring in the same cycle.
                if (done_edge_s) begin
                    if (m_ack_error && retry_ok_s) begin
                        state_n      = SCHED_GUARD;
                        retry_cnt_n  = retry_cnt_r + RTY_W'(1);
                        retry_pend_n = 1'b1;
                    end else begin
                        state_n                 = SCHED_RESP;
                        rsp_valid_n             = gnt_oh_r;
                        rsp_data_n              = (m_rw && !m_ack_error) ? m_rdata : 8'h00;
                        rsp_err_n[ERR_NACK_BIT] = m_ack_error;
                    end
                end else if (cnt_r == TMO_LAST) begin
                    state_n                = SCHED_RESP;
                    rsp_valid_n            = gnt_oh_r;
                    rsp_err_n[ERR_TMO_BIT] = 1'b1;
                end else begin
                    state_n = SCHED_WAIT;
                end
            end
            SCHED_RESP: begin
                state_n      = SCHED_GUARD;
                retry_pend_n = 1'b0;
            end
            SCHED_GUARD: begin
                if (cnt_r == GRD_LAST) begin
                    state_n      = retry_pend_r ? SCHED_ISSUE : SCHED_IDLE;
                    retry_pend_n = 1'b0;
                end else begin
                    state_n = SCHED_GUARD;
                end
            end
            default: begin
                state_n = SCHED_IDLE;
            end
        endcase
        // One shared counter: timeout in WAIT, gap length in GUARD; restarts on every state change.
        if ((state_n != state_r) || (state_r == SCHED_IDLE)) begin
            cnt_n = '0;
        end else begin
            cnt_n = cnt_r + CNT_W'(1);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= SCHED_IDLE;
            rr_ptr_r     <= IDX_W'(NUM_REQ - 1);
            gnt_oh_r     <= '0;
            cnt_r        <= '0;
            retry_cnt_r  <= '0;
            retry_pend_r <= 1'b0;
            m_done_q_r   <= 1'b0;
            req_ack      <= '0;
            rsp_valid    <= '0;
            rsp_data     <= 8'h00;
            rsp_err      <= 2'b00;
            busy         <= 1'b0;
            m_start      <= 1'b0;
            m_addr       <= 7'h00;
            m_rw         <= 1'b0;
            m_wdata      <= 8'h00;
        end else begin
            state_r      <= state_n;
            rr_ptr_r     <= rr_ptr_n;
            gnt_oh_r     <= gnt_oh_n;
            cnt_r        <= cnt_n;
            retry_cnt_r  <= retry_cnt_n;
            retry_pend_r <= retry_pend_n;
            m_done_q_r   <= m_done;
            req_ack      <= req_ack_n;
            rsp_valid    <= rsp_valid_n;
            rsp_data     <= rsp_data_n;
            rsp_err      <= rsp_err_n;
            busy         <= (state_n != SCHED_IDLE);
            m_start      <= (state_n == SCHED_ISSUE);
            m_addr       <= m_addr_n;
            m_rw         <= m_rw_n;
            m_wdata      <= m_wdata_n;
        end
    end

endmodule
